conv_requant_stage: RTL
=======================

// Module: conv_requant_stage
// PURPOSE
//  Parametrised output stage after the conv accumulator/shift tree. Per lane: optional rounding right-shift, zero-point add, activation clamp, saturation to WIDTH_DATA.
//  L = PICTURE_NUM*CHANNEL_OUT_NUM lanes; lane k = j*PICTURE_NUM+i occupies bits [k*W +: W].
//  Two-stage pipeline with valid/ready backpressure and a saturation-event counter. Feeds the pooling/write-back path.
// PARAMETERS
//  PICTURE_NUM      1   pictures processed in parallel
//  CHANNEL_OUT_NUM  8   output channels per beat
//  WIDTH_DATA       8   output width W; input lane width is 2W, signed
//  ZP_WIDTH         8   zero-point width, unsigned
//  SHIFT_WIDTH      5   width of the requant shift amount
//  CNT_WIDTH        32  width of the saturation counter
// PORTS
//  clk         in   1           rising-edge clock
//  rst_n       in   1           asynchronous active-low reset
//  s_valid     in   1           input beat valid
//  s_ready     out  1           input beat accepted when s_valid&&s_ready
//  s_data      in   L*2W        signed accumulator lanes
//  zero_point  in   ZP_WIDTH    sampled with each accepted beat
//  shift_amt   in   SHIFT_WIDTH sampled with each accepted beat
//  act_mode    in   2           00 sat, 01 relu, 10 relu-clip, 11 reserved (= 00); sampled with beat
//  clip_max    in   W           upper bound for mode 10; sampled with beat
//  m_valid     out  1           output beat valid
//  m_ready     in   1           downstream ready
//  m_data      out  L*W         unsigned result lanes
//  sat_clr     in   1           synchronous clear of sat_cnt
//  sat_cnt     out  CNT_WIDTH   count of beats with at least one lane clamped
// BEHAVIOUR
//  Reset: v1, v2 (= m_valid) = 0; m_data = 0; sat_cnt = 0; carried config regs = 0. Reset mid-stream drops all in-flight beats.
//  Stage 1 (S1) captures at s_fire: y = rshift(s_data lane) + zero_point, sign-extended to 2W+1 bits, no overflow.
//  Stage 2 (S2) clamps y:
//    mode 00 -> [0, 2^W-1]
//    mode 01 -> [zp, 2^W-1]
//    mode 10 -> [zp, min(clip_max, 2^W-1)]; if clip_max < zp the result is zp.
//  Latency: 2 cycles s_fire -> m_valid with no stall. Throughput 1 beat/clk.
//  Handshake:
//    adv2 = !v2 || m_ready; adv1 = !v1 || adv2; s_ready = adv1 (combinational from m_ready, one gate level).
//    m_data and m_valid are held stable while m_valid && !m_ready; no beat is dropped or duplicated.
//    Bubbles collapse: an empty S2 accepts S1 even when m_ready = 0.
//  Clamp flag: set when any lane's pre-clamp y lies outside its mode's range; it travels with the beat.
//  sat_cnt: +1 at each m_fire whose flag is set; saturates at all-ones.
//    sat_clr wins over a simultaneous increment: the count becomes 0 that cycle.
//  Zero point and shift apply in S1; mode and clip_max are carried with the beat and apply in S2, so config may change every beat.
// CONFIGURATION
//  CONV_REQUANT_ROUND_SHIFT_EN defined:
//    rshift(x) = (x + (1 << (s-1))) >>> s for s > 0, round half up; s = 0 passes x.
//    s >= 2W is treated as 2W-1.
//  Undefined: rshift(x) = x; shift_amt is ignored, and the port remains so the port list is unchanged.
// STRUCTURE
//  Package conv_requant_pkg:
//    mode localparams MODE_SAT = 2'd0, MODE_RELU = 2'd1, MODE_CLIP = 2'd2
//    lane-count localparam L
//    function sat_u(y, lo, hi) returning {flag, value}
//  Sub-module conv_requant_lane: per-lane combinational shift/add and clamp, instanced L times in a generate loop.
//  Pipeline registers, handshake logic and counter stay in the top module.
// TESTING
//  1. W=8, lane = -300, zp = 10, mode 00, no stall -> m_data lane 0 at cycle +2, flag set, sat_cnt = 1.
//  2. lane = 100, zp = 20, mode 10, clip_max = 110 -> 110, flag set. Same beat with mode 01 -> 120, flag clear.
//  3. 4 back-to-back beats with m_ready low for cycles 2-5:
//     -> s_ready drops after S1 and S2 fill; outputs appear in order, each held stable; zero loss or duplication.
//  4. ROUND_SHIFT_EN, shift = 2, lane = 6 -> S1 = 2 (6+2 = 8, >>2); lane = -7 -> -2 (-7+2 = -5, >>>2); zp = 0, mode 00 -> 2 and 0.
//  5. rst_n low while both stages are full -> m_valid = 0 and sat_cnt = 0 immediately; first beat after release appears at +2.
//  6. sat_clr asserted in the same cycle as a flagged m_fire -> sat_cnt = 0. Preset counter to all-ones with a flagged beat -> stays all-ones.

Source files
------------

// File: rtl/conv_requant_pkg.sv
// Shared definitions for the conv requantisation stage: activation mode codes,
// default lane count and the unsigned saturation helper.
package conv_requant_pkg;

  localparam logic [1:0] MODE_SAT  = 2'd0;
  localparam logic [1:0] MODE_RELU = 2'd1;
  localparam logic [1:0] MODE_CLIP = 2'd2;

  localparam int PICTURE_NUM_DEF     = 1;
  localparam int CHANNEL_OUT_NUM_DEF = 8;
  localparam int L = PICTURE_NUM_DEF * CHANNEL_OUT_NUM_DEF;

  // Wide enough for any 2W+1 lane value at the widths this block is built for.
  localparam int SAT_W = 64;
  typedef logic signed [SAT_W-1:0] sat_val_t;

  typedef struct packed {
    logic     flag;
    sat_val_t value;
  } sat_res_t;

  // An empty range (hi < lo) pins the result to lo and always flags.
  function automatic sat_res_t sat_u(input sat_val_t y, input sat_val_t lo, input sat_val_t hi);
    sat_res_t r;
    if (hi < lo) begin
      r.flag  = 1'b1;
      r.value = lo;
    end else if (y < lo) begin
      r.flag  = 1'b1;
      r.value = lo;
    end else if (y > hi) begin
      r.flag  = 1'b1;
      r.value = hi;
    end else begin
      r.flag  = 1'b0;
      r.value = y;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_requant_lane.sv
// One requant lane: S1 shift + zero-point add and S2 activation clamp, both combinational.
// Rounding right-shift is built only when CONV_REQUANT_ROUND_SHIFT_EN is defined.
module conv_requant_lane
  import conv_requant_pkg::*;
#(
  parameter int WIDTH_DATA  = 8,
  parameter int ZP_WIDTH    = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic        [2*WIDTH_DATA-1:0] i_acc,
  input  logic        [ZP_WIDTH-1:0]     i_zp,
  input  logic        [SHIFT_WIDTH-1:0]  i_shift,
  output logic signed [2*WIDTH_DATA:0]   o_y,
  input  logic signed [2*WIDTH_DATA:0]   i_y,
  input  logic        [1:0]              i_mode,
  input  logic        [WIDTH_DATA-1:0]   i_clip_max,
  input  logic        [ZP_WIDTH-1:0]     i_zp_q,
  output logic        [WIDTH_DATA-1:0]   o_data,
  output logic                           o_flag
);

  localparam int XW = 2 * WIDTH_DATA;
  localparam int YW = XW + 1;
  localparam sat_val_t MAXV = (sat_val_t'(1) <<< WIDTH_DATA) - sat_val_t'(1);

  logic signed [YW-1:0] w_x;
  logic signed [YW-1:0] w_sh;

  assign w_x = YW'($signed(i_acc));

`ifdef CONV_REQUANT_ROUND_SHIFT_EN
  logic        [SHIFT_WIDTH-1:0] w_s;
  logic signed [YW-1:0]          w_rnd;

  assign w_s   = (int'(i_shift) >= XW) ? SHIFT_WIDTH'(XW - 1) : i_shift;
  // One extra bit keeps x + half from wrapping before the arithmetic shift.
  assign w_rnd = (w_s == '0) ? w_x : w_x + (YW'(1) << (w_s - SHIFT_WIDTH'(1)));
  assign w_sh  = w_rnd >>> w_s;
`else
  logic w_unused_shift;
  assign w_unused_shift = ^i_shift;
  assign w_sh           = w_x;
`endif

  assign o_y = w_sh + YW'(i_zp);

  sat_val_t w_lo;
  sat_val_t w_hi;
  sat_res_t w_res;
  logic     w_unused_hi;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_lo = '0;
    w_hi = MAXV;
    case (i_mode)
      MODE_RELU: w_lo = SAT_W'(i_zp_q);
      MODE_CLIP: begin
        w_lo = SAT_W'(i_zp_q);
        w_hi = SAT_W'(i_clip_max);
      end
      default: ;
    endcase
  end

  assign w_res       = sat_u(SAT_W'(i_y), w_lo, w_hi);
  assign o_data      = w_res.value[WIDTH_DATA-1:0];
  assign o_flag      = w_res.flag;
  assign w_unused_hi = ^w_res.value[SAT_W-1:WIDTH_DATA];

endmodule

// File: rtl/conv_requant_stage.sv
// Two-stage requant output pipeline with valid/ready backpressure and a saturation counter.
// Optional rounding shift enabled by defining CONV_REQUANT_ROUND_SHIFT_EN.
module conv_requant_stage
  import conv_requant_pkg::*;
#(
  parameter int PICTURE_NUM     = 1,
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA      = 8,
  parameter int ZP_WIDTH        = 8,
  parameter int SHIFT_WIDTH     = 5,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  input  logic [PICTURE_NUM*CHANNEL_OUT_NUM*2*WIDTH_DATA-1:0] s_data,
  input  logic [ZP_WIDTH-1:0]                           zero_point,
  input  logic [SHIFT_WIDTH-1:0]                        shift_amt,
  input  logic [1:0]                                    act_mode,
  input  logic [WIDTH_DATA-1:0]                         clip_max,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [PICTURE_NUM*CHANNEL_OUT_NUM*WIDTH_DATA-1:0] m_data,
  input  logic                                          sat_clr,
  output logic [CNT_WIDTH-1:0]                          sat_cnt
);

  localparam int W     = WIDTH_DATA;
  localparam int LANES = PICTURE_NUM * CHANNEL_OUT_NUM;
  localparam int YW    = 2 * W + 1;

  logic                   r_v1;
  logic [LANES*YW-1:0]    r_y1;
  logic [ZP_WIDTH-1:0]    r_zp1;
  logic [1:0]             r_mode1;
  logic [W-1:0]           r_clip1;
  logic                   r_v2;
  logic [LANES*W-1:0]     r_data2;
  logic                   r_flag2;
  logic [CNT_WIDTH-1:0]   r_cnt;

  logic                   w_adv1;
  logic                   w_adv2;
  logic                   w_s_fire;
  logic                   w_m_fire;
  logic [LANES*YW-1:0]    w_y;
  logic [LANES*W-1:0]     w_data;
  logic [LANES-1:0]       w_flag;

  assign w_adv2   = !r_v2 || m_ready;
  assign w_adv1   = !r_v1 || w_adv2;
  assign w_s_fire = s_valid && w_adv1;
  assign w_m_fire = r_v2 && m_ready;

  assign s_ready = w_adv1;
  assign m_valid = r_v2;
  assign m_data  = r_data2;
  assign sat_cnt = r_cnt;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    conv_requant_lane #(
      .WIDTH_DATA (W),
      .ZP_WIDTH   (ZP_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .i_acc     (s_data[k*2*W +: 2*W]),
      .i_zp      (zero_point),
      .i_shift   (shift_amt),
      .o_y       (w_y[k*YW +: YW]),
      .i_y       (r_y1[k*YW +: YW]),
      .i_mode    (r_mode1),
      .i_clip_max(r_clip1),
      .i_zp_q    (r_zp1),
      .o_data    (w_data[k*W +: W]),
      .o_flag    (w_flag[k])
    );
  end

  // NOTE: data registers are reset as well as the valids, so m_data reads 0
  // after reset instead of stale or unknown lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1    <= 1'b0;
      r_y1    <= '0;
      r_zp1   <= '0;
      r_mode1 <= MODE_SAT;
      r_clip1 <= '0;
      r_v2    <= 1'b0;
      r_data2 <= '0;
      r_flag2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage read the pre-edge value
      // of its upstream register, which is what makes the pipeline shift.
      if (w_adv1) r_v1 <= s_valid;
      if (w_s_fire) begin
        r_y1    <= w_y;
        r_zp1   <= zero_point;
        r_mode1 <= act_mode;
        r_clip1 <= clip_max;
      end
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv2 && r_v1) begin
        r_data2 <= w_data;
        r_flag2 <= |w_flag;
      end
    end
  end

  // Clear beats a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (sat_clr) begin
      r_cnt <= '0;
    end else if (w_m_fire && r_flag2 && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
